sc_dec_insn_list_buf: RTL and testbench

- Byte-serial receiver and buffer for decoded-instruction records produced by the simulator decoder stream.
- Reassembles fixed-layout insn_info records (len, ins, ext, typ, dis fields) from a byte stream, stores up to LIST_CAP records in a FIFO, and presents one unpacked record at a time to the checker/trace logic.
- Generalises the fixed decoder list layout: field sizes, list depth and retained disassembly length are all parameters, and an entry-validity check is added.

---
 rtl/sc_dec_insn_list_buf.sv | 142 ++++++++++++++
 tb/tb_sc_dec_insn_list_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_dec_insn_list_buf.sv
// rtl/sc_dec_insn_list_buf.sv - byte-serial insn_info record assembler with record FIFO
module sc_dec_insn_list_buf #(
    parameter int LEN_SIZE = 8,
    parameter int INS_SIZE = 8,
    parameter int EXT_SIZE = 1,
    parameter int TYP_SIZE = 1,
    parameter int DIS_SIZE = 64,
    parameter int DIS_KEEP = 64,
    parameter int LIST_CAP = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*LEN_SIZE-1:0]         out_len,
    output logic [8*INS_SIZE-1:0]         out_ins,
    output logic [8*EXT_SIZE-1:0]         out_ext,
    output logic [8*TYP_SIZE-1:0]         out_typ,
    output logic [8*DIS_KEEP-1:0]         out_dis,
    output logic                          out_bad,
    output logic [$clog2(LIST_CAP):0]     count,
    output logic                          overrun
);
    localparam int INFO_SIZE = LEN_SIZE + INS_SIZE + EXT_SIZE + TYP_SIZE + DIS_SIZE;
    localparam int LEN_OFF   = 0;
    localparam int INS_OFF   = LEN_OFF + LEN_SIZE;
    localparam int EXT_OFF   = INS_OFF + INS_SIZE;
    localparam int TYP_OFF   = EXT_OFF + EXT_SIZE;
    localparam int DIS_OFF   = TYP_OFF + TYP_SIZE;
    localparam int IDX_W     = $clog2(INFO_SIZE);
    localparam int PTR_W     = $clog2(LIST_CAP);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LEN_W     = 8 * LEN_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INFO_SIZE - 1);

    logic [IDX_W-1:0]        idx;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [8*LEN_SIZE-1:0]   asm_len, nxt_len;
    logic [8*INS_SIZE-1:0]   asm_ins, nxt_ins;
    logic [8*EXT_SIZE-1:0]   asm_ext, nxt_ext;
    logic [8*TYP_SIZE-1:0]   asm_typ, nxt_typ;
    logic [8*DIS_KEEP-1:0]   asm_dis, nxt_dis;
    logic                    nxt_bad;

    logic [8*LEN_SIZE-1:0]   mem_len [LIST_CAP];
    logic [8*INS_SIZE-1:0]   mem_ins [LIST_CAP];
    logic [8*EXT_SIZE-1:0]   mem_ext [LIST_CAP];
    logic [8*TYP_SIZE-1:0]   mem_typ [LIST_CAP];
    logic [8*DIS_KEEP-1:0]   mem_dis [LIST_CAP];
    logic                    mem_bad [LIST_CAP];

    logic accept, push, pop;

    assign in_ready  = (idx != LAST_IDX) || (count != CNT_W'(LIST_CAP));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (idx == LAST_IDX);
    assign pop       = out_valid && out_ready;

    // Assembly view including the current byte, so the final byte is pushed with its record.
    always_comb begin
        nxt_len = asm_len;
        nxt_ins = asm_ins;
        nxt_ext = asm_ext;
        nxt_typ = asm_typ;
        nxt_dis = asm_dis;
        for (int k = 0; k < LEN_SIZE; k++)
            if (idx == IDX_W'(LEN_OFF + k)) nxt_len[8*k +: 8] = in_byte;
        for (int k = 0; k < INS_SIZE; k++)
            if (idx == IDX_W'(INS_OFF + k)) nxt_ins[8*k +: 8] = in_byte;
        for (int k = 0; k < EXT_SIZE; k++)
            if (idx == IDX_W'(EXT_OFF + k)) nxt_ext[8*k +: 8] = in_byte;
        for (int k = 0; k < TYP_SIZE; k++)
            if (idx == IDX_W'(TYP_OFF + k)) nxt_typ[8*k +: 8] = in_byte;
        for (int k = 0; k < DIS_KEEP; k++)
            if (idx == IDX_W'(DIS_OFF + k)) nxt_dis[8*k +: 8] = in_byte;
        nxt_bad = (nxt_len == '0) || (nxt_len > LEN_W'(INS_SIZE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            overrun <= 1'b0;
            asm_len <= '0;
            asm_ins <= '0;
            asm_ext <= '0;
            asm_typ <= '0;
            asm_dis <= '0;
        end else if (flush) begin
            idx     <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            asm_len <= '0;
            asm_ins <= '0;
            asm_ext <= '0;
            asm_typ <= '0;
            asm_dis <= '0;
            if (idx != '0) overrun <= 1'b1;
        end else begin
            if (accept) begin
                idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                asm_len <= nxt_len;
                asm_ins <= nxt_ins;
                asm_ext <= nxt_ext;
                asm_typ <= nxt_typ;
                asm_dis <= nxt_dis;
            end
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset; head/tail/count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_len[tail] <= nxt_len;
            mem_ins[tail] <= nxt_ins;
            mem_ext[tail] <= nxt_ext;
            mem_typ[tail] <= nxt_typ;
            mem_dis[tail] <= nxt_dis;
            mem_bad[tail] <= nxt_bad;
        end
    end

    assign out_len = mem_len[head];
    assign out_ins = mem_ins[head];
    assign out_ext = mem_ext[head];
    assign out_typ = mem_typ[head];
    assign out_dis = mem_dis[head];
    assign out_bad = mem_bad[head];
endmodule

// File: tb/tb_sc_dec_insn_list_buf.sv
// tb/tb_sc_dec_insn_list_buf.sv - queue-model bench for sc_dec_insn_list_buf (default and DIS_KEEP=16)
module tb_sc_dec_insn_list_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]   in_byte = 8'h00;

    logic         a_in_ready, a_out_valid, a_out_bad, a_overrun;
    logic [63:0]  a_out_len, a_out_ins;
    logic [7:0]   a_out_ext, a_out_typ;
    logic [511:0] a_out_dis;
    logic [4:0]   a_count;

    logic         b_in_ready, b_out_valid, b_out_bad, b_overrun;
    logic [63:0]  b_out_len, b_out_ins;
    logic [7:0]   b_out_ext, b_out_typ;
    logic [127:0] b_out_dis;
    logic [4:0]   b_count;

    sc_dec_insn_list_buf u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_byte(in_byte), .out_valid(a_out_valid), .out_ready(out_ready), .out_len(a_out_len),
        .out_ins(a_out_ins), .out_ext(a_out_ext), .out_typ(a_out_typ), .out_dis(a_out_dis),
        .out_bad(a_out_bad), .count(a_count), .overrun(a_overrun)
    );

    sc_dec_insn_list_buf #(.DIS_KEEP(16)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_byte(in_byte), .out_valid(b_out_valid), .out_ready(out_ready), .out_len(b_out_len),
        .out_ins(b_out_ins), .out_ext(b_out_ext), .out_typ(b_out_typ), .out_dis(b_out_dis),
        .out_bad(b_out_bad), .count(b_count), .overrun(b_overrun)
    );

    typedef struct {
        logic [63:0]  len;
        logic [63:0]  ins;
        logic [7:0]   ext;
        logic [7:0]   typ;
        logic [511:0] dis;
        logic         bad;
    } rec_t;

    rec_t       mq[$];
    logic [7:0] part[$];
    logic       m_overrun = 1'b0;
    int         tests = 0, fails = 0;
    bit         chk_en = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk_rec();
        rec_t r;
        r.len = '0; r.ins = '0; r.dis = '0;
        for (int i = 0; i < 8; i++) r.len[8*i +: 8] = part[i];
        for (int i = 0; i < 8; i++) r.ins[8*i +: 8] = part[8 + i];
        r.ext = part[16];
        r.typ = part[17];
        for (int i = 0; i < 64; i++) r.dis[8*i +: 8] = part[18 + i];
        r.bad = (r.len == 0) || (r.len > 8);
        return r;
    endfunction

    function automatic bit m_ready();
        return (part.size() != 81) || (mq.size() != 16);
    endfunction

    // Reference model: records are byte lists that become entries after 82 accepted bytes.
    always @(posedge clk) begin
        bit rdy;
        rdy = m_ready();
        if (rst) begin
            mq.delete(); part.delete(); m_overrun = 1'b0;
        end else if (flush) begin
            if (part.size() != 0) m_overrun = 1'b1;
            mq.delete(); part.delete();
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                part.push_back(in_byte);
                if (part.size() == 82) begin
                    mq.push_back(mk_rec());
                    part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_in_ready", a_in_ready, m_ready());
            chk("b_in_ready", b_in_ready, m_ready());
            chk("a_out_valid", a_out_valid, mq.size() != 0);
            chk("b_out_valid", b_out_valid, mq.size() != 0);
            chk("a_count", a_count, mq.size());
            chk("b_count", b_count, mq.size());
            chk("a_overrun", a_overrun, m_overrun);
            chk("b_overrun", b_overrun, m_overrun);
            if (mq.size() != 0) begin
                chk("a_out_len", a_out_len, mq[0].len);
                chk("a_out_ins", a_out_ins, mq[0].ins);
                chk("a_out_ext", a_out_ext, mq[0].ext);
                chk("a_out_typ", a_out_typ, mq[0].typ);
                chk("a_out_dis", a_out_dis, mq[0].dis);
                chk("a_out_bad", a_out_bad, mq[0].bad);
                chk("b_out_len", b_out_len, mq[0].len);
                chk("b_out_ins", b_out_ins, mq[0].ins);
                chk("b_out_dis", b_out_dis, mq[0].dis[127:0]);
                chk("b_out_bad", b_out_bad, mq[0].bad);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = a_in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    task automatic send_rec(input logic [63:0] len, input logic [63:0] ins, input logic [7:0] ext,
                            input logic [7:0] typ, input logic [511:0] dis, input int n);
        logic [7:0] bs[82];
        for (int i = 0; i < 8; i++) bs[i] = len[8*i +: 8];
        for (int i = 0; i < 8; i++) bs[8 + i] = ins[8*i +: 8];
        bs[16] = ext;
        bs[17] = typ;
        for (int i = 0; i < 64; i++) bs[18 + i] = dis[8*i +: 8];
        for (int i = 0; i < n; i++) send_byte(bs[i]);
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] dis_s, dis_inc;
        string s;
        s = "add a0,t1,a1";
        dis_s = '0;
        for (int k = 0; k < s.len(); k++) dis_s[8*k +: 8] = s[k];
        dis_inc = '0;
        for (int k = 0; k < 64; k++) dis_inc[8*k +: 8] = 8'h41 + 8'(k);

        rst = 1'b1;
        step(); step();
        chk_en = 1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_count", a_count, 5'd0);
        chk("rst_overrun", a_overrun, 1'b0);
        rst = 1'b0;
        step();

        // Single record with defaults
        send_rec(64'd4, 64'h0000_0000_00b3_0533, 8'h01, 8'h02, dis_s, 82);
        chk("one_valid", a_out_valid, 1'b1);
        chk("one_len", a_out_len, 64'd4);
        chk("one_ins", a_out_ins, 64'hb30533);
        chk("one_ext", a_out_ext, 8'h01);
        chk("one_typ", a_out_typ, 8'h02);
        chk("one_bad", a_out_bad, 1'b0);
        chk("one_count", a_count, 5'd1);
        pop1();

        // Fill to capacity, then stall the 17th record's final byte
        for (int r = 0; r < 16; r++)
            send_rec(64'(r % 8 + 1), 64'h1000 + 64'(r), 8'(r), 8'(r + 3), dis_inc, 82);
        chk("fill_count", a_count, 5'd16);
        send_rec(64'd1, 64'hdead_beef, 8'h11, 8'h22, dis_s, 81);
        in_valid = 1'b1;
        in_byte  = 8'h00;
        step(); step();
        chk("full_stall", a_in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_pop_count", a_count, 5'd15);
        chk("full_ready_again", a_in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("full_refill_count", a_count, 5'd16);
        out_ready = 1'b1;
        repeat (17) step();
        out_ready = 1'b0;
        chk("drain_count", a_count, 5'd0);

        // Concurrent push and pop at count 3
        for (int r = 1; r <= 3; r++) send_rec(64'(r), 64'h2000 + 64'(r), 8'h0, 8'h0, dis_s, 82);
        send_rec(64'd4, 64'h2004, 8'h0, 8'h0, dis_s, 81);
        in_valid  = 1'b1;
        in_byte   = 8'h5a;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", a_count, 5'd3);
        chk("pp_head_len", a_out_len, 64'd2);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;

        // Bad length flag
        send_rec(64'd0, 64'h1, 8'h0, 8'h0, dis_s, 82);
        send_rec(64'd9, 64'h2, 8'h0, 8'h0, dis_s, 82);
        send_rec(64'd2, 64'h3, 8'h0, 8'h0, dis_s, 82);
        chk("bad_len0", a_out_bad, 1'b1);
        pop1();
        chk("bad_len9", a_out_bad, 1'b1);
        pop1();
        chk("bad_len2", a_out_bad, 1'b0);
        pop1();

        // Truncated dis and alignment of the following record
        send_rec(64'd5, 64'h55, 8'h0, 8'h0, dis_inc, 82);
        send_rec(64'd3, 64'h33, 8'h0, 8'h0, dis_s, 82);
        chk("trunc_dis", b_out_dis, 128'h504f4e4d4c4b4a494847464544434241);
        chk("trunc_len", b_out_len, 64'd5);
        pop1();
        chk("trunc_next_len", b_out_len, 64'd3);
        pop1();

        // Flush mid-record, then reset mid-record
        send_rec(64'd1, 64'h1, 8'h0, 8'h0, dis_s, 82);
        send_rec(64'd2, 64'h2, 8'h0, 8'h0, dis_s, 82);
        send_rec(64'd3, 64'h3, 8'h0, 8'h0, dis_s, 40);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_count", a_count, 5'd0);
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_overrun", a_overrun, 1'b1);
        send_rec(64'd6, 64'h66, 8'h06, 8'h07, dis_inc, 82);
        chk("post_flush_len", a_out_len, 64'd6);
        chk("post_flush_ins", a_out_ins, 64'h66);
        pop1();
        send_rec(64'd8, 64'h88, 8'h0, 8'h0, dis_s, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clr_overrun", a_overrun, 1'b0);
        chk("rst_clr_count", a_count, 5'd0);
        send_rec(64'd7, 64'h77, 8'h0, 8'h0, dis_s, 82);
        chk("post_rst_len", a_out_len, 64'd7);
        pop1();
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
